seq_stream_gen: RTL and testbench

Serial pattern transmitter: loads a parallel bit pattern and shifts it out MSB-first, one bit per clock, repeated a programmable number of times. It is the stimulus source for the serial sequence detector (mealy_seq): its `x` output drives the detector's `x` input on the same clock. A start/busy/done handshake lets a controller or bench queue patterns without counting cycles.

---
 rtl/seq_stream_gen.sv | 148 ++++++++++++++
 tb/tb_seq_stream_gen.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/seq_stream_gen.sv
`default_nettype none
// ============================================================================
//  Module   : seq_stream_gen
//  Purpose  : Serial pattern transmitter. Shifts a captured pattern out
//             MSB-first, one bit per clock, repeated reps+1 times.
//  Revision : 1.0 - initial release
// ============================================================================
module seq_stream_gen #(
    parameter int WIDTH = 16,
    parameter int LW    = 5
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] data,
    input  logic [LW-1:0]    len,
    input  logic [3:0]       reps,
    output logic             x,
    output logic             valid,
    output logic             busy,
    output logic             done
);

    localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_SEND = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [WIDTH-1:0] r_pat;
    logic [WIDTH-1:0] w_pat_nxt;
    logic [IW-1:0]    r_last;
    logic [IW-1:0]    w_last_nxt;
    logic [IW-1:0]    r_idx;
    logic [IW-1:0]    w_idx_nxt;
    logic [3:0]       r_rep;
    logic [3:0]       w_rep_nxt;
    logic             r_x;
    logic             w_x_nxt;
    logic             r_valid;
    logic             w_valid_nxt;
    logic             r_busy;
    logic             w_busy_nxt;
    logic             r_done;
    logic             w_done_nxt;
    logic [IW-1:0]    w_eff_last;
    logic [IW-1:0]    w_idx_dec;

    // A length of zero or above WIDTH selects the full pattern width.
    always_comb begin
        if ((len == '0) || (len > LW'(WIDTH))) begin
            w_eff_last = IW'(WIDTH - 1);
        end else begin
            w_eff_last = IW'(len - 1'b1);
        end
    end

    assign w_idx_dec = r_idx - 1'b1;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_pat   <= '0;
            r_last  <= '0;
            r_idx   <= '0;
            r_rep   <= '0;
            r_x     <= 1'b0;
            r_valid <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_pat   <= w_pat_nxt;
            r_last  <= w_last_nxt;
            r_idx   <= w_idx_nxt;
            r_rep   <= w_rep_nxt;
            r_x     <= w_x_nxt;
            r_valid <= w_valid_nxt;
            r_busy  <= w_busy_nxt;
            r_done  <= w_done_nxt;
        end
    end

    // Outputs are computed one cycle ahead and registered with the state.
    always_comb begin
        w_state_nxt = r_state;
        w_pat_nxt   = r_pat;
        w_last_nxt  = r_last;
        w_idx_nxt   = r_idx;
        w_rep_nxt   = r_rep;
        w_x_nxt     = 1'b0;
        w_valid_nxt = 1'b0;
        w_busy_nxt  = 1'b0;
        w_done_nxt  = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_pat_nxt   = data;
                    w_last_nxt  = w_eff_last;
                    w_idx_nxt   = w_eff_last;
                    w_rep_nxt   = reps;
                    w_x_nxt     = data[w_eff_last];
                    w_valid_nxt = 1'b1;
                    w_busy_nxt  = 1'b1;
                    w_state_nxt = S_SEND;
                end
            end

            S_SEND: begin
                w_busy_nxt = 1'b1;
                if (r_idx != '0) begin
                    w_idx_nxt   = w_idx_dec;
                    w_x_nxt     = r_pat[w_idx_dec];
                    w_valid_nxt = 1'b1;
                end else if (r_rep != 4'd0) begin
                    // Reload with no idle gap between repetitions.
                    w_idx_nxt   = r_last;
                    w_rep_nxt   = r_rep - 4'd1;
                    w_x_nxt     = r_pat[r_last];
                    w_valid_nxt = 1'b1;
                end else begin
                    w_done_nxt  = 1'b1;
                    w_state_nxt = S_DONE;
                end
            end

            S_DONE: begin
                w_state_nxt = S_IDLE;
            end

            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    assign x     = r_x;
    assign valid = r_valid;
    assign busy  = r_busy;
    assign done  = r_done;

endmodule
`default_nettype wire

// File: tb/tb_seq_stream_gen.sv
`default_nettype none
// ============================================================================
//  Module   : tb_seq_stream_gen
//  Purpose  : Scoreboard bench for seq_stream_gen with directed patterns.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_seq_stream_gen;

    logic        clk;
    logic        rst;
    logic        start;
    logic [15:0] data;
    logic [4:0]  len;
    logic [3:0]  reps;
    logic        x;
    logic        valid;
    logic        busy;
    logic        done;

    typedef struct packed {
        logic d;
        logic b;
    } exp_t;

    exp_t q[$];
    int   checks   = 0;
    int   failures = 0;
    bit   mon_active = 0;
    bit   prev_done  = 0;

    seq_stream_gen #(.WIDTH(16), .LW(5)) dut (
        .clock (clk),
        .reset (rst),
        .start (start),
        .data  (data),
        .len   (len),
        .reps  (reps),
        .x     (x),
        .valid (valid),
        .busy  (busy),
        .done  (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic push_exp(input string bits);
        exp_t e;
        for (int i = 0; i < bits.len(); i++) begin
            e.d = 1'b0;
            e.b = (bits[i] == "1");
            q.push_back(e);
        end
        e.d = 1'b1;
        e.b = 1'b0;
        q.push_back(e);
    endtask

    task automatic drain();
        for (int k = 0; k < 400 && q.size() != 0; k++) @(negedge clk);
        if (q.size() != 0) begin
            chk("drain_timeout", q.size(), 0);
            q.delete();
        end
        @(negedge clk);
    endtask

    task automatic send(input logic [15:0] d, input logic [4:0] l, input logic [3:0] r,
                        input string bits);
        @(posedge clk);
        #1;
        data  = d;
        len   = l;
        reps  = r;
        start = 1'b1;
        push_exp(bits);
        @(posedge clk);
        #1;
        start = 1'b0;
        data  = 16'hFFFF;
        len   = 5'd3;
        reps  = 4'd7;
        drain();
    endtask

    // Monitor: pops one expected entry for every cycle the DUT presents a bit or done.
    always @(negedge clk) begin
        if (!rst) begin
            if (prev_done) begin
                chk("idle_after_done", {31'd0, valid | busy | done}, 32'd0);
                prev_done = 0;
            end
            if (valid || done) begin
                if (q.size() == 0) begin
                    chk("unexpected_output", {30'd0, valid, done}, 32'd0);
                end else begin
                    exp_t e;
                    e = q.pop_front();
                    if (e.d) chk("done_cycle", {28'd0, x, valid, busy, done}, {28'd0, 4'b0011});
                    else     chk("bit", {28'd0, x, valid, busy, done}, {28'd0, e.b, 3'b110});
                    prev_done  = e.d;
                    mon_active = !e.d;
                end
            end else if (mon_active) begin
                chk("gap", {31'd0, valid}, 32'd1);
                mon_active = 0;
            end
        end
    end

    initial begin
        rst   = 1'b1;
        start = 1'b1;
        data  = 16'h0009;
        len   = 5'd4;
        reps  = 4'd0;
        #3;
        chk("reset_outputs_t3", {28'd0, x, valid, busy, done}, 32'd0);
        @(posedge clk);
        #1;
        chk("reset_outputs_held", {28'd0, x, valid, busy, done}, 32'd0);
        #3;
        start = 1'b0;
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk("idle_after_reset", {28'd0, x, valid, busy, done}, 32'd0);

        send(16'h0009, 5'd4, 4'd0, "1001");
        send(16'h0009, 5'd4, 4'd2, "100110011001");
        send(16'hA5C3, 5'd0, 4'd0, "1010010111000011");
        send(16'hA5C3, 5'd20, 4'd0, "1010010111000011");
        send(16'h0003, 5'd1, 4'd2, "111");
        send(16'h0035, 5'd6, 4'd1, "110101110101");
        send(16'h0002, 5'd2, 4'd15, "10101010101010101010101010101010");
        send(16'h8001, 5'd16, 4'd0, "1000000000000001");

        // Held start: data changes mid-flight, second run starts after the idle cycle.
        @(posedge clk);
        #1;
        data  = 16'h0009;
        len   = 5'd4;
        reps  = 4'd0;
        start = 1'b1;
        push_exp("1001");
        push_exp("0110");
        @(posedge clk);
        @(posedge clk);
        #1;
        data = 16'h0006;
        begin
            int k;
            for (k = 0; k < 50 && !done; k++) @(negedge clk);
            if (!done) chk("held_done_timeout", {31'd0, done}, 32'd1);
        end
        @(posedge clk);
        @(posedge clk);
        #1;
        start = 1'b0;
        chk("held_second_start", {29'd0, x, valid, busy}, {29'd0, 3'b011});
        drain();

        // Asynchronous reset after two bits.
        @(posedge clk);
        #1;
        data  = 16'h0009;
        len   = 5'd4;
        reps  = 4'd0;
        start = 1'b1;
        push_exp("1001");
        @(posedge clk);
        #1;
        start = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #3;
        chk("pre_reset_busy", {31'd0, busy}, 32'd1);
        rst = 1'b1;
        mon_active = 0;
        prev_done  = 0;
        #1;
        chk("async_reset_outputs", {28'd0, x, valid, busy, done}, 32'd0);
        q.delete();
        @(posedge clk);
        #1;
        chk("reset_held_outputs", {28'd0, x, valid, busy, done}, 32'd0);
        rst = 1'b0;
        send(16'h0009, 5'd4, 4'd0, "1001");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
